// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the raw bus, decodes 11-bit frames,
// folds E0/F0 prefixes into flags and queues key events in a first-word-fall-through FIFO.
module ps2_event_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int ERR_W       = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  output logic [7:0]                    ev_data,
  output logic                          ev_ext,
  output logic                          ev_brk,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [ERR_W-1:0]              err_cnt,
  output logic [2:0]                    err_code
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int FC_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'b000,
    ERR_START   = 3'b001,
    ERR_PARITY  = 3'b010,
    ERR_STOP    = 3'b011,
    ERR_TIMEOUT = 3'b100
  } err_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } event_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and glitch filter; bit 0 carries PS2_CLK, bit 1 carries PS2_DAT.
  // ---------------------------------------------------------------------------
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            filt_q, filt_d;
  logic [1:0][FC_W-1:0]  fcnt_q, fcnt_d;
  logic                  clk_prev_q;
  logic                  strobe;
  logic                  bit_val;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      filt_q     <= '1;
      fcnt_q     <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      // NOTE: every register here updates with <= so all flops sample pre-edge values together.
      sync1_q    <= {PS2_DAT, PS2_CLK};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      clk_prev_q <= filt_q[0];
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FC_W'(FILTER_LEN - 1)) begin
        filt_d[i] = sync2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  assign strobe  = clk_prev_q & ~filt_q[0];
  assign bit_val = filt_q[1];

  // ---------------------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                ext_pend_q, ext_pend_d;
  logic                brk_pend_q, brk_pend_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  err_e                err_code_q, err_code_d;
  logic                push_q, push_d;
  event_t              push_ev_q, push_ev_d;
  logic                err_now;
  err_e                err_val;
  logic                timeout;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      err_cnt_q  <= '0;
      err_code_q <= ERR_NONE;
      push_q     <= 1'b0;
      push_ev_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      err_cnt_q  <= err_cnt_d;
      err_code_q <= err_code_d;
      push_q     <= push_d;
      push_ev_q  <= push_ev_d;
    end
  end

  // The watchdog counts cycles since the last strobe; it never fires in a strobe cycle.
  assign timeout = (state_q != S_IDLE) && !strobe &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    err_cnt_d  = err_cnt_q;
    err_code_d = err_code_q;
    push_d     = 1'b0;
    push_ev_d  = push_ev_q;
    err_now    = 1'b0;
    err_val    = ERR_NONE;

    if ((state_q == S_IDLE) || strobe) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (strobe) begin
          if (!bit_val) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            err_now = 1'b1;
            err_val = ERR_START;
          end
        end
      end
      S_DATA: begin
        if (strobe) begin
          shift_d = {bit_val, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (strobe) begin
          par_d   = bit_val;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (strobe) begin
          state_d = S_IDLE;
          // Parity is judged first so a frame with both faults reports a parity error.
          if (!(^{shift_q, par_q})) begin
            err_now = 1'b1;
            err_val = ERR_PARITY;
          end else if (!bit_val) begin
            err_now = 1'b1;
            err_val = ERR_STOP;
          end else if (shift_q == CODE_EXT) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == CODE_BRK) begin
            brk_pend_d = 1'b1;
          end else begin
            push_d     = 1'b1;
            push_ev_d  = '{ext: ext_pend_q, brk: brk_pend_q, code: shift_q};
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_IDLE;
      err_now = 1'b1;
      err_val = ERR_TIMEOUT;
    end

    if (err_now) begin
      err_code_d = err_val;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  event_t           mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             full;
  logic             pop;
  logic             do_push;
  logic             ovf_set;
  event_t           head;

  assign full     = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign ev_valid = (count_q != '0);
  assign pop      = ev_valid & ev_ready;
  assign do_push  = push_q & (~full | pop);
  assign ovf_set  = push_q & full & ~pop;

  // NOTE: storage has no reset; an empty FIFO masks it, so only pointers and count need one.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_ev_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
      // A new drop outranks a clear in the same cycle.
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign head                      = mem_q[rd_ptr_q];
  assign {ev_ext, ev_brk, ev_data} = ev_valid ? head : '0;
  assign fifo_level                = count_q;
  assign overflow                  = overflow_q;
  assign err_cnt                   = err_cnt_q;
  assign err_code                  = err_code_q;

endmodule

// File: tb/tb_ps2_event_rx.sv
// Self-checking bench for ps2_event_rx: directed scenarios plus randomized frames,
// compared against a frame-level reference model with an expected-event queue.
module tb_ps2_event_rx;

  localparam int DEPTH   = 4;
  localparam int FLEN    = 4;
  localparam int TOUT    = 300;
  localparam int ERRW    = 8;
  localparam int HALF    = 10;
  localparam int LAT     = 2 + FLEN;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int ERR_MAX = (1 << ERRW) - 1;

  logic             CLOCK_50 = 1'b0;
  logic             reset_n  = 1'b1;
  logic             PS2_CLK  = 1'b1;
  logic             PS2_DAT  = 1'b1;
  logic             ev_ready = 1'b0;
  logic             ovf_clr  = 1'b0;
  logic [7:0]       ev_data;
  logic             ev_ext;
  logic             ev_brk;
  logic             ev_valid;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic [ERRW-1:0]  err_cnt;
  logic [2:0]       err_code;

  ps2_event_rx #(
    .FIFO_DEPTH (DEPTH),
    .FILTER_LEN (FLEN),
    .TIMEOUT_CYC(TOUT),
    .ERR_W      (ERRW)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .ev_data   (ev_data),
    .ev_ext    (ev_ext),
    .ev_brk    (ev_brk),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .err_cnt   (err_cnt),
    .err_code  (err_code)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: what a correct receiver reports, frame by frame.
  logic [9:0]  exp_q[$];
  bit          m_ext, m_brk, m_ovf;
  int          m_err_cnt;
  logic [2:0]  m_err_code;
  bit          rnd_rdy = 1'b0;

  task automatic m_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_err_cnt = 0; m_err_code = 3'b000;
  endtask

  task automatic m_err(input logic [2:0] c);
    m_err_code = c;
    if (m_err_cnt < ERR_MAX) m_err_cnt++;
    m_ext = 0; m_brk = 0;
  endtask

  task automatic m_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    if (bad_par)             m_err(3'b010);
    else if (bad_stop)       m_err(3'b011);
    else if (code == 8'hE0)  m_ext = 1;
    else if (code == 8'hF0)  m_brk = 1;
    else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, code});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Consumer monitor: every accepted event must be the oldest expected one.
  always @(negedge CLOCK_50) begin
    if (reset_n && ev_valid && ev_ready) begin
      check("ev_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("ev_pop", {ev_ext, ev_brk, ev_data}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLOCK_50); #1;
      if (rnd_rdy) ev_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input bit bad_par,
                                              input bit bad_stop);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = code;
    f[9]   = ~(^code) ^ bad_par;
    f[10]  = ~bad_stop;
    return f;
  endfunction

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    cyc(HALF);
    PS2_CLK = 1'b0;
    cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_partial(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  // The stop bit is timed so the push cycle (strobe + 1) can be probed or paired with a pop.
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input bit pulse_rdy, input bit chk_timing);
    logic [10:0] f;
    f = make_frame(code, bad_par, bad_stop);
    send_partial(f, 10);
    PS2_DAT = f[10];
    cyc(HALF);
    PS2_CLK = 1'b0;
    cyc(LAT + 1);
    if (chk_timing) check("valid_early", 32'(ev_valid), 32'd0);
    if (pulse_rdy) ev_ready = 1'b1;
    cyc(1);
    if (pulse_rdy) ev_ready = 1'b0;
    if (chk_timing) check("valid_latency", 32'(ev_valid), 32'd1);
    m_frame(code, bad_par, bad_stop);
    cyc(HALF - LAT - 2);
    PS2_CLK = 1'b1;
    cyc(HALF);
  endtask

  task automatic start_err();
    ps2_bit(1'b1);
    cyc(HALF);
    m_err(3'b001);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".err_cnt"},  32'(err_cnt),    m_err_cnt);
    check({tag, ".err_code"}, 32'(err_code),   32'(m_err_code));
    check({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
    check({tag, ".level"},    32'(fifo_level), exp_q.size());
  endtask

  task automatic check_head(input string tag);
    if (exp_q.size() != 0) check({tag, ".head"}, {ev_ext, ev_brk, ev_data}, exp_q[0]);
    else                   check({tag, ".head0"}, {ev_valid, ev_ext, ev_brk, ev_data}, 0);
  endtask

  task automatic drain(input string tag);
    ev_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !ev_valid) break;
      cyc(1);
    end
    ev_ready = 1'b0;
    cyc(1);
    check({tag, ".drained"}, exp_q.size(), 0);
    check({tag, ".empty"}, {fifo_level, ev_valid, ev_ext, ev_brk, ev_data}, 0);
  endtask

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] code;
    int         r;
    int         kind;

    m_reset();
    #2 reset_n = 1'b0;
    #1;
    check_status("reset");
    check_head("reset");
    cyc(3);
    reset_n = 1'b1;
    cyc(5);

    // Single frame, latency and head contents.
    send_frame(8'h1C, 0, 0, 0, 1);
    check("t1c.data", 32'(ev_data), 32'h1C);
    check_head("t1c");
    check_status("t1c");
    drain("t1c");

    // Prefix folding.
    send_frame(8'hF0, 0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0, 0);
    check("prefix.head", {ev_ext, ev_brk, ev_data}, {2'b01, 8'h1C});
    check_status("prefix");
    drain("prefix");

    // Frame errors and recovery; an error also discards a pending prefix.
    send_frame(8'h1C, 1, 0, 0, 0);
    check_status("par_err");
    send_frame(8'h1C, 0, 0, 0, 0);
    check_head("par_ok");
    drain("par_ok");
    send_frame(8'h3A, 0, 1, 0, 0);
    check_status("stop_err");
    send_frame(8'h44, 1, 1, 0, 0);
    check_status("both_err");
    start_err();
    check_status("start_err");
    send_frame(8'hE0, 0, 0, 0, 0);
    send_frame(8'h12, 1, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0, 0);
    check_head("pend_clr");
    drain("pend_clr");

    // Timeout mid-frame.
    send_partial(make_frame(8'h29, 0, 0), 5);
    cyc(TOUT + 50);
    m_err(3'b100);
    check_status("timeout");
    send_frame(8'h29, 0, 0, 0, 0);
    check("timeout.next", 32'(ev_data), 32'h29);
    drain("timeout");

    // Overflow on a full FIFO, then clear.
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 0, 0, 0, 0);
    check_status("ovf");
    check_head("ovf");
    drain("ovf");
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    m_ovf = 0;
    check_status("ovf_clr");

    // Full FIFO with a pop in the push cycle: no overflow, level unchanged.
    for (int i = 0; i < DEPTH; i++) send_frame(8'h20 + 8'(i), 0, 0, 0, 0);
    send_frame(8'h30, 0, 0, 1, 0);
    check_status("full_pop");
    check_head("full_pop");
    drain("full_pop");

    // Reset in the middle of a frame.
    send_frame(8'h55, 0, 0, 0, 0);
    send_frame(8'h66, 1, 0, 0, 0);
    send_partial(make_frame(8'h66, 0, 0), 4);
    reset_n = 1'b0;
    #1;
    m_reset();
    check_status("mid_reset");
    check_head("mid_reset");
    cyc(3);
    reset_n = 1'b1;
    cyc(3);
    send_frame(8'h5A, 0, 0, 0, 0);
    check_head("after_reset");
    check_status("after_reset");
    drain("after_reset");

    // Randomized frames with a randomly stalling consumer.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r    = int'($urandom_range(0, 99));
      kind = int'($urandom_range(0, 9));
      code = 8'($urandom);
      if (r < 12)      code = 8'hE0;
      else if (r < 24) code = 8'hF0;
      case (kind)
        0:       start_err();
        1:       send_frame(code, 1, 0, 0, 0);
        2:       send_frame(code, 0, 1, 0, 0);
        default: send_frame(code, 0, 0, 0, 0);
      endcase
      check_status("rand");
    end
    rnd_rdy = 1'b0;
    cyc(2);
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
